watch_counter: RTL and testbench
================================

# watch_counter

Time-of-day counter fed directly by the clock generator's one-second output. Counts seconds, minutes and hours in packed BCD (00:00:00 to 23:59:59) from rising edges of Clock_1Sec. Supports a set mode that freezes time and lets push-buttons step minutes and hours. Its outputs drive the display decoder stage.

## Interface
- Parameters: none (all limits fixed as package constants).
- Clock_5K  in  1  system clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Clock_1Sec  in  1  one-second square wave from the clock generator, same clock domain. Each 0→1 transition is one second.
- Set_Mode  in  1  level. 1 = SET, 0 = RUN.
- Inc_Min  in  1  button level; each 0→1 edge is one minute step (SET only).
- Inc_Hour  in  1  button level; each 0→1 edge is one hour step (SET only).
- Sec_BCD  out  8  seconds, packed BCD, 8'h00–8'h59.
- Min_BCD  out  8  minutes, packed BCD, 8'h00–8'h59.
- Hour_BCD  out  8  hours, packed BCD, 8'h00–8'h23.
- Sec_Tick  out  1  one-cycle pulse when Sec_BCD advances.
- Day_Wrap  out  1  one-cycle pulse when 23:59:59 advances to 00:00:00.

## Operation
- Edge detection:
  - Clock_1Sec, Set_Mode, Inc_Min and Inc_Hour each pass through a 2-flop synchronizer followed by a previous-value register.
  - An edge is defined as sync2 && !prev.
  - All of these registers reset to 0.
- FSM has two states, RUN and SET. Reset state is RUN.
  - RUN→SET: synchronized Set_Mode = 1. In the transition cycle, Sec_BCD is cleared to 8'h00.
  - SET→RUN: synchronized Set_Mode = 0.
- RUN behaviour, on each Clock_1Sec edge:
  - Seconds increment.
  - 59→00 carries into minutes. Minutes 59→00 carries into hours. Hours 23→00 asserts Day_Wrap.
  - Inc_Min and Inc_Hour edges are ignored.
- SET behaviour:
  - Clock_1Sec edges are discarded. Sec_BCD is held at 8'h00 and Sec_Tick stays 0.
  - Inc_Min edge: minutes step 59→00 with no carry into hours.
  - Inc_Hour edge: hours step 23→00 with no Day_Wrap.
  - Both button edges in the same cycle: both fields step.
- BCD arithmetic:
  - Low nibble 9 rolls to 0 and increments the high nibble.
  - Field maximum rolls the whole field to 8'h00.
  - Non-BCD values are unreachable; no saturation logic.
- Simultaneous events:
  - Clock_1Sec edge in the cycle the FSM enters SET: the tick is dropped.
  - Clock_1Sec edge in the cycle the FSM returns to RUN: the tick counts; Sec_BCD becomes 8'h01.
- Reset mid-operation:
  - All outputs go to 0 asynchronously. Reset values: Sec_BCD/Min_BCD/Hour_BCD = 8'h00, Sec_Tick = 0, Day_Wrap = 0.
  - After release, counting starts at the first Clock_1Sec edge seen by the synchronizer.

## Timing
- Input 0→1 sampled at Clock_5K edge k → updated count (and Sec_Tick/Day_Wrap) visible after edge k+2. Latency is 3 clock edges including the sampling edge.
- Sec_Tick and Day_Wrap are registered, high for exactly one Clock_5K cycle, coincident with the updated count.
- Set_Mode change → FSM state change after the same 3-edge latency.
- Button edges must be spaced ≥2 Clock_5K cycles apart; debounce is done upstream.

## Configuration
- ALARM_EN defined:
  - Adds inputs Alarm_Hour_BCD [7:0], Alarm_Min_BCD [7:0], Alarm_Off [0:0] and output Alarm [0:0].
  - Alarm sets to 1 in RUN when a seconds rollover produces Hour:Min equal to the alarm value with Sec = 00. This happens in the same cycle as Sec_Tick.
  - Alarm clears on an Alarm_Off edge, on entering SET, or on reset. Reset value is 0.
- ALARM_EN undefined: none of these ports or registers exist.

## Structure
- Package watch_pkg holds:
  - BCD limit constants: SEC_MAX_BCD = 8'h59, MIN_MAX_BCD = 8'h59, HOUR_MAX_BCD = 8'h23.
  - FSM state typedef: RUN, SET.
- Sub-module bcd_mod_counter:
  - Two-digit packed-BCD counter with inputs inc and max and output carry.
  - Instantiated three times, once each for seconds, minutes and hours.
- Top level holds the synchronizers, edge detectors, FSM and (when ALARM_EN is defined) the alarm compare.

## Test plan
- Reset asserted mid-count at 12:34:56 → all outputs 0 immediately. After release, 5 Clock_1Sec edges → 00:00:05.
- Preload 00:00:58 via SET, then RUN with 2 edges → 00:01:00. Sec_Tick pulses twice, each one cycle wide.
- Reach 23:59:59, then 1 edge → 00:00:00 with Day_Wrap high for one cycle.
- In SET: 61 Inc_Min edges → Min 8'h01, Hour unchanged. 25 Inc_Hour edges → Hour 8'h01. Clock_1Sec edges during SET leave Sec at 8'h00.
- Clock_1Sec edge in the same cycle as the Set_Mode rise → no increment. Edge in the same cycle as the Set_Mode fall → Sec 8'h01.
- ALARM_EN, alarm set to 07:30, run from 07:29:58 → Alarm rises when the count reaches 07:30:00. An Alarm_Off edge clears it.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants, FSM state type and BCD step helper for the time-of-day counter.
package watch_pkg;

    localparam logic [7:0] SEC_MAX_BCD  = 8'h59;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;
    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } watch_state_t;

    // One packed-BCD step; the field maximum wraps the whole field to zero.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
        logic [7:0] result;
        if (value == max)
            result = 8'h00;
        else if (value[3:0] == 4'd9)
            result = {value[7:4] + 4'd1, 4'd0};
        else
            result = {value[7:4], value[3:0] + 4'd1};
        return result;
    endfunction

endpackage

// File: rtl/watch_counter_if.sv
// Control inputs and BCD display outputs of watch_counter; ALARM_EN adds the alarm signals.
interface watch_counter_if;

    logic       Clock_1Sec;
    logic       Set_Mode;
    logic       Inc_Min;
    logic       Inc_Hour;
    logic [7:0] Sec_BCD;
    logic [7:0] Min_BCD;
    logic [7:0] Hour_BCD;
    logic       Sec_Tick;
    logic       Day_Wrap;
`ifdef ALARM_EN
    logic [7:0] Alarm_Hour_BCD;
    logic [7:0] Alarm_Min_BCD;
    logic [0:0] Alarm_Off;
    logic [0:0] Alarm;
`endif

    modport master (
        output Clock_1Sec, Set_Mode, Inc_Min, Inc_Hour,
`ifdef ALARM_EN
        output Alarm_Hour_BCD, Alarm_Min_BCD, Alarm_Off,
        input  Alarm,
`endif
        input  Sec_BCD, Min_BCD, Hour_BCD, Sec_Tick, Day_Wrap
    );

    modport slave (
        input  Clock_1Sec, Set_Mode, Inc_Min, Inc_Hour,
`ifdef ALARM_EN
        input  Alarm_Hour_BCD, Alarm_Min_BCD, Alarm_Off,
        output Alarm,
`endif
        output Sec_BCD, Min_BCD, Hour_BCD, Sec_Tick, Day_Wrap
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping at max; carry flags the wrapping step.
module bcd_mod_counter
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] max,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && (value == max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= 8'h00;
        else if (clr)
            value <= 8'h00;
        else if (inc)
            value <= bcd_inc(value, max);
    end

endmodule

// File: rtl/watch_counter.sv
// BCD time-of-day counter with RUN/SET modes; define ALARM_EN to add the HH:MM alarm.
module watch_counter
    import watch_pkg::*;
(
    input  logic          Clock_5K,
    input  logic          Reset,
    watch_counter_if.slave bus
);

`ifdef ALARM_EN
    localparam int NSYNC = 5;
`else
    localparam int NSYNC = 4;
`endif

    logic [NSYNC-1:0] raw, sync1, sync2, prev, rise;
    watch_state_t     state;
    logic             sec_tick, day_wrap;
    logic [7:0]       sec_value, min_value, hour_value;
    logic             sec_carry, min_carry, hour_carry;

`ifdef ALARM_EN
    assign raw = {bus.Alarm_Off[0], bus.Inc_Hour, bus.Inc_Min, bus.Set_Mode, bus.Clock_1Sec};
`else
    assign raw = {bus.Inc_Hour, bus.Inc_Min, bus.Set_Mode, bus.Clock_1Sec};
`endif

    always_ff @(posedge Clock_5K or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // A Set_Mode rise is exactly the RUN->SET transition cycle; leaving SET behaves as RUN.
    logic set_lvl, entering, run_act, set_act, run_tick;
    assign set_lvl  = sync2[1];
    assign entering = rise[1];
    assign run_act  = !set_lvl;
    assign set_act  = set_lvl && (state == SET);
    assign run_tick = run_act && rise[0];

    logic min_inc, hour_inc;
    assign min_inc  = run_act ? sec_carry : (set_act && rise[2]);
    assign hour_inc = run_act ? min_carry : (set_act && rise[3]);

    bcd_mod_counter u_sec (
        .clk(Clock_5K), .rst(Reset), .inc(run_tick), .clr(entering),
        .max(SEC_MAX_BCD), .value(sec_value), .carry(sec_carry)
    );

    bcd_mod_counter u_min (
        .clk(Clock_5K), .rst(Reset), .inc(min_inc), .clr(1'b0),
        .max(MIN_MAX_BCD), .value(min_value), .carry(min_carry)
    );

    bcd_mod_counter u_hour (
        .clk(Clock_5K), .rst(Reset), .inc(hour_inc), .clr(1'b0),
        .max(HOUR_MAX_BCD), .value(hour_value), .carry(hour_carry)
    );

`ifdef ALARM_EN
    logic       alarm, alarm_hit;
    logic [7:0] min_next, hour_next;
    // HH:MM as it will read after this rollover; only meaningful when sec_carry is set.
    assign min_next  = bcd_inc(min_value, MIN_MAX_BCD);
    assign hour_next = min_carry ? bcd_inc(hour_value, HOUR_MAX_BCD) : hour_value;
    assign alarm_hit = run_tick && sec_carry &&
                       (min_next == bus.Alarm_Min_BCD) && (hour_next == bus.Alarm_Hour_BCD);
    assign bus.Alarm = alarm;
`endif

    always_ff @(posedge Clock_5K or posedge Reset) begin
        if (Reset) begin
            state    <= RUN;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
`ifdef ALARM_EN
            alarm    <= 1'b0;
`endif
        end else begin
            state    <= set_lvl ? SET : RUN;
            sec_tick <= run_tick;
            day_wrap <= run_act && hour_carry;
`ifdef ALARM_EN
            if (entering || rise[4])
                alarm <= 1'b0;
            else if (alarm_hit)
                alarm <= 1'b1;
`endif
        end
    end

    assign bus.Sec_BCD  = sec_value;
    assign bus.Min_BCD  = min_value;
    assign bus.Hour_BCD = hour_value;
    assign bus.Sec_Tick = sec_tick;
    assign bus.Day_Wrap = day_wrap;

endmodule

// File: tb/tb_watch_counter.sv
// Directed bench for watch_counter: seconds-of-day model compared every cycle plus literal checkpoints.
module tb_watch_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    watch_counter_if bus();

    watch_counter dut (
        .Clock_5K(clk),
        .Reset(rst),
        .bus(bus)
    );

    int errors = 0;
    int total  = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;
    int alarm_h = 0;
    int alarm_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Model: time of day as seconds since midnight; input events are seen two edges after sampling.
    int   tod;
    bit   m_tick, m_wrap, m_alarm;
    logic [4:0] h1, h2, h3, ev, cur;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tod = 0; m_tick = 0; m_wrap = 0; m_alarm = 0;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            bit hit;
            hit = 0;
            ev = h2 & ~h3;
            m_tick = 0;
            m_wrap = 0;
`ifdef ALARM_EN
            cur = {bus.Alarm_Off[0], bus.Inc_Hour, bus.Inc_Min, bus.Set_Mode, bus.Clock_1Sec};
`else
            cur = {1'b0, bus.Inc_Hour, bus.Inc_Min, bus.Set_Mode, bus.Clock_1Sec};
`endif
            if (!h2[1]) begin
                if (ev[0]) begin
                    m_tick = 1;
                    if (tod == 86399) m_wrap = 1;
                    tod = (tod + 1) % 86400;
                    if (tod % 60 == 0 && tod / 3600 == alarm_h && (tod / 60) % 60 == alarm_m)
                        hit = 1;
                end
            end else if (!h3[1]) begin
                tod = tod - tod % 60;
            end else begin
                if (ev[2]) tod = (tod / 3600) * 3600 + (((tod / 60) % 60 + 1) % 60) * 60 + tod % 60;
                if (ev[3]) tod = (((tod / 3600) + 1) % 24) * 3600 + tod % 3600;
            end
            if (ev[4] || (h2[1] && !h3[1])) m_alarm = 0;
            else if (hit) m_alarm = 1;
            h3 = h2; h2 = h1; h1 = cur;
        end
    end

    always @(negedge clk) begin
        chk("sec",  {24'd0, bus.Sec_BCD},  {24'd0, to_bcd(tod % 60)});
        chk("min",  {24'd0, bus.Min_BCD},  {24'd0, to_bcd((tod / 60) % 60)});
        chk("hour", {24'd0, bus.Hour_BCD}, {24'd0, to_bcd(tod / 3600)});
        chk("tick", {31'd0, bus.Sec_Tick}, {31'd0, m_tick});
        chk("wrap", {31'd0, bus.Day_Wrap}, {31'd0, m_wrap});
`ifdef ALARM_EN
        chk("alarm", {31'd0, bus.Alarm[0]}, {31'd0, m_alarm});
`endif
        if (bus.Sec_Tick === 1'b1) tick_cnt++;
        if (bus.Day_Wrap === 1'b1) wrap_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sec_edges(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Clock_1Sec = 1'b1; cyc(3);
            bus.Clock_1Sec = 1'b0; cyc(3);
        end
    endtask

    task automatic min_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Inc_Min = 1'b1; cyc(2);
            bus.Inc_Min = 1'b0; cyc(2);
        end
    endtask

    task automatic hour_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Inc_Hour = 1'b1; cyc(2);
            bus.Inc_Hour = 1'b0; cyc(2);
        end
    endtask

    task automatic set_mode(input logic v);
        bus.Set_Mode = v;
        cyc(5);
    endtask

    task automatic chk_time(input string nm, input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        chk({nm, ".hour"}, {24'd0, bus.Hour_BCD}, {24'd0, hh});
        chk({nm, ".min"},  {24'd0, bus.Min_BCD},  {24'd0, mm});
        chk({nm, ".sec"},  {24'd0, bus.Sec_BCD},  {24'd0, ss});
    endtask

    initial begin
        bus.Clock_1Sec = 1'b0;
        bus.Set_Mode   = 1'b0;
        bus.Inc_Min    = 1'b0;
        bus.Inc_Hour   = 1'b0;
`ifdef ALARM_EN
        bus.Alarm_Hour_BCD = 8'h00;
        bus.Alarm_Min_BCD  = 8'h00;
        bus.Alarm_Off      = 1'b0;
        alarm_h = 0;
        alarm_m = 0;
`else
        alarm_h = -1;
        alarm_m = -1;
`endif
        cyc(3);
        chk_time("reset", 8'h00, 8'h00, 8'h00);
        chk("reset.tick", {31'd0, bus.Sec_Tick}, 32'd0);
        chk("reset.wrap", {31'd0, bus.Day_Wrap}, 32'd0);
        rst = 1'b0;
        cyc(1);
`ifdef ALARM_EN
        // Keep the alarm out of reach until its own test.
        bus.Alarm_Hour_BCD = 8'h99;
        alarm_h = 99;
`endif

        // Reach 12:34:56, then reset between clock edges.
        set_mode(1'b1);
        hour_steps(12);
        min_steps(34);
        set_mode(1'b0);
        sec_edges(56);
        chk_time("preset", 8'h12, 8'h34, 8'h56);
        #2 rst = 1'b1;
        #1 chk_time("async_reset", 8'h00, 8'h00, 8'h00);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        sec_edges(5);
        chk_time("after_reset", 8'h00, 8'h00, 8'h05);

        // Seconds rollover into minutes.
        sec_edges(53);
        chk_time("at58", 8'h00, 8'h00, 8'h58);
        tick_cnt = 0;
        sec_edges(2);
        chk_time("carry_min", 8'h00, 8'h01, 8'h00);
        chk("tick_count", tick_cnt, 32'd2);

        // Day wrap from 23:59:59.
        set_mode(1'b1);
        hour_steps(23);
        min_steps(58);
        set_mode(1'b0);
        sec_edges(59);
        chk_time("at_235959", 8'h23, 8'h59, 8'h59);
        wrap_cnt = 0;
        sec_edges(1);
        chk_time("day_wrap", 8'h00, 8'h00, 8'h00);
        chk("wrap_count", wrap_cnt, 32'd1);

        // SET mode stepping without carries; 1 s edges ignored.
        set_mode(1'b1);
        min_steps(61);
        chk_time("set_min61", 8'h00, 8'h01, 8'h00);
        hour_steps(25);
        chk_time("set_hour25", 8'h01, 8'h01, 8'h00);
        tick_cnt = 0;
        sec_edges(3);
        chk_time("set_sec_hold", 8'h01, 8'h01, 8'h00);
        chk("set_no_tick", tick_cnt, 32'd0);

        // 1 s edge coincident with entering and with leaving SET.
        set_mode(1'b0);
        sec_edges(4);
        chk_time("run4", 8'h01, 8'h01, 8'h04);
        bus.Clock_1Sec = 1'b1; bus.Set_Mode = 1'b1; cyc(3);
        bus.Clock_1Sec = 1'b0; cyc(3);
        chk_time("enter_set_drop", 8'h01, 8'h01, 8'h00);
        bus.Clock_1Sec = 1'b1; bus.Set_Mode = 1'b0; cyc(3);
        bus.Clock_1Sec = 1'b0; cyc(3);
        chk_time("leave_set_count", 8'h01, 8'h01, 8'h01);

`ifdef ALARM_EN
        bus.Alarm_Hour_BCD = 8'h07;
        bus.Alarm_Min_BCD  = 8'h30;
        alarm_h = 7;
        alarm_m = 30;
        set_mode(1'b1);
        hour_steps(6);
        min_steps(28);
        set_mode(1'b0);
        sec_edges(58);
        chk_time("alarm_pre", 8'h07, 8'h29, 8'h58);
        sec_edges(1);
        chk("alarm_low", {31'd0, bus.Alarm[0]}, 32'd0);
        bus.Clock_1Sec = 1'b1; cyc(3);
        chk_time("alarm_time", 8'h07, 8'h30, 8'h00);
        chk("alarm_rise", {31'd0, bus.Alarm[0]}, 32'd1);
        bus.Clock_1Sec = 1'b0; cyc(3);
        bus.Alarm_Off = 1'b1; cyc(2);
        bus.Alarm_Off = 1'b0; cyc(3);
        chk("alarm_off", {31'd0, bus.Alarm[0]}, 32'd0);
`endif

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule
